nunchuk_input_decoder: RTL and testbench



---
 rtl/nunchuk_input_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_nunchuk_input_decoder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nunchuk_input_decoder.sv
// nunchuk_input_decoder
// Registered nunchuk frame decoder. It latches each 6-byte frame on frame_valid and
// unpacks the stick, accelerometer and button fields. It also provides frame-counted
// button debounce with press pulses, deadzone direction decoding and auto-repeat
// direction events.
// Optional feature: define NUNCHUK_ACCEL_FILTER_EN to run each accelerometer output
// through a first-order IIR filter. Leave it undefined to get the raw latched fields.

module nunchuk_input_decoder #(
    parameter int ACCEL_W         = 10,
    parameter int CENTER          = 128,
    parameter int DEADZONE        = 40,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 5,
    parameter int FILTER_SHIFT    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_valid,
    input  logic [7:0]         data_in [5:0],
    output logic [7:0]         stick_x,
    output logic [7:0]         stick_y,
    output logic [ACCEL_W-1:0] accel_x,
    output logic [ACCEL_W-1:0] accel_y,
    output logic [ACCEL_W-1:0] accel_z,
    output logic               z_btn,
    output logic               c_btn,
    output logic               z_press,
    output logic               c_press,
    output logic [3:0]         dir_level,
    output logic [3:0]         dir_evt
);

    // Stick thresholds are kept in 9-bit signed form so that a small CENTER minus a
    // large DEADZONE can go negative without wrapping.
    localparam logic signed [8:0] HI_TH = 9'(CENTER + DEADZONE);
    localparam logic signed [8:0] LO_TH = 9'(CENTER - DEADZONE);

    // The repeat counter only has to reach the larger of the delay and the period.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [3:0]       DEB_LAST    = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // Field extraction from the incoming frame.
    logic [9:0]         full_ax;
    logic [9:0]         full_ay;
    logic [9:0]         full_az;
    logic [ACCEL_W-1:0] raw_ax;
    logic [ACCEL_W-1:0] raw_ay;
    logic [ACCEL_W-1:0] raw_az;
    logic signed [8:0]  stick_sx;
    logic signed [8:0]  stick_sy;

    // Per-button state: index 0 is Z and index 1 is C.
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [3:0] btn_count [2];

    // Per-axis state: index 0 is X (pos = right) and index 1 is Y (pos = up).
    logic [1:0]       axis_pos;
    logic [1:0]       axis_neg;
    logic [1:0]       axis_pos_evt;
    logic [1:0]       axis_neg_evt;
    logic [1:0]       axis_last_pos;
    rpt_state_t       axis_state [2];
    logic [RPT_W-1:0] axis_cnt   [2];

    assign full_ax = {data_in[2], data_in[5][3:2]};
    assign full_ay = {data_in[3], data_in[5][5:4]};
    assign full_az = {data_in[4], data_in[5][7:6]};
    assign raw_ax  = full_ax[9 -: ACCEL_W];
    assign raw_ay  = full_ay[9 -: ACCEL_W];
    assign raw_az  = full_az[9 -: ACCEL_W];

    // The buttons are active-low in the frame.
    assign btn_raw = {~data_in[5][1], ~data_in[5][0]};

    assign stick_sx = $signed({1'b0, data_in[0]});
    assign stick_sy = $signed({1'b0, data_in[1]});

    assign axis_pos[0] = (stick_sx > HI_TH);
    assign axis_neg[0] = (stick_sx < LO_TH);
    assign axis_pos[1] = (stick_sy > HI_TH);
    assign axis_neg[1] = (stick_sy < LO_TH);

    assign z_btn   = btn_level[0];
    assign c_btn   = btn_level[1];
    assign z_press = btn_press[0];
    assign c_press = btn_press[1];
    assign dir_evt = {axis_pos_evt[1], axis_neg_evt[1], axis_neg_evt[0], axis_pos_evt[0]};

    // Latch the stick values and the decoded direction level once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            stick_x   <= 8'(CENTER);
            stick_y   <= 8'(CENTER);
            dir_level <= '0;
        end else if (frame_valid) begin
            stick_x   <= data_in[0];
            stick_y   <= data_in[1];
            dir_level <= {axis_pos[1], axis_neg[1], axis_neg[0], axis_pos[0]};
        end
    end

`ifdef NUNCHUK_ACCEL_FILTER_EN
    logic filt_loaded;

    // One IIR step. The signed difference is one bit wider than the sample, and the
    // arithmetic shift floors toward minus infinity so the result stays between acc and raw.
    function automatic logic [ACCEL_W-1:0] iir_step(input logic [ACCEL_W-1:0] acc,
                                                    input logic [ACCEL_W-1:0] raw);
        logic signed [ACCEL_W:0] diff;
        logic signed [ACCEL_W:0] sum;
        diff = $signed({1'b0, raw}) - $signed({1'b0, acc});
        sum  = $signed({1'b0, acc}) + (diff >>> FILTER_SHIFT);
        return sum[ACCEL_W-1:0];
    endfunction

    // Filter the accelerometer per frame. The first frame after reset seeds the filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            accel_x     <= '0;
            accel_y     <= '0;
            accel_z     <= '0;
            filt_loaded <= 1'b0;
        end else if (frame_valid) begin
            filt_loaded <= 1'b1;
            if (!filt_loaded) begin
                accel_x <= raw_ax;
                accel_y <= raw_ay;
                accel_z <= raw_az;
            end else begin
                accel_x <= iir_step(accel_x, raw_ax);
                accel_y <= iir_step(accel_y, raw_ay);
                accel_z <= iir_step(accel_z, raw_az);
            end
        end
    end
`else
    // Latch the raw accelerometer fields once per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            accel_x <= '0;
            accel_y <= '0;
            accel_z <= '0;
        end else if (frame_valid) begin
            accel_x <= raw_ax;
            accel_y <= raw_ay;
            accel_z <= raw_az;
        end
    end
`endif

    // Debounce both buttons. The level flips after DEBOUNCE_FRAMES consecutive
    // disagreeing frames, and a rising flip produces a single press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level <= '0;
            btn_press <= '0;
            for (int i = 0; i < 2; i++) begin
                btn_count[i] <= '0;
            end
        end else begin
            btn_press <= '0;
            if (frame_valid) begin
                for (int i = 0; i < 2; i++) begin
                    if (btn_raw[i] == btn_level[i]) begin
                        btn_count[i] <= '0;
                    end else if (btn_count[i] + 4'd1 == DEB_LAST) begin
                        btn_level[i] <= btn_raw[i];
                        btn_press[i] <= btn_raw[i];
                        btn_count[i] <= '0;
                    end else begin
                        btn_count[i] <= btn_count[i] + 4'd1;
                    end
                end
            end
        end
    end

    // Auto-repeat FSM for each axis. A fresh press or a reversal fires at once and then
    // waits REPEAT_DELAY frames. After that it fires every REPEAT_PERIOD frames. A neutral
    // axis returns to idle. With REPEAT_DELAY of zero the FSM parks in DELAY.
    always_ff @(posedge clk) begin
        if (reset) begin
            axis_pos_evt  <= '0;
            axis_neg_evt  <= '0;
            axis_last_pos <= '0;
            for (int i = 0; i < 2; i++) begin
                axis_state[i] <= RPT_IDLE;
                axis_cnt[i]   <= '0;
            end
        end else begin
            axis_pos_evt <= '0;
            axis_neg_evt <= '0;
            if (frame_valid) begin
                for (int i = 0; i < 2; i++) begin
                    if (!(axis_pos[i] || axis_neg[i])) begin
                        axis_state[i] <= RPT_IDLE;
                        axis_cnt[i]   <= '0;
                    end else if ((axis_state[i] == RPT_IDLE) || (axis_pos[i] != axis_last_pos[i])) begin
                        axis_pos_evt[i]  <= axis_pos[i];
                        axis_neg_evt[i]  <= axis_neg[i];
                        axis_last_pos[i] <= axis_pos[i];
                        axis_state[i]    <= RPT_DELAY;
                        axis_cnt[i]      <= '0;
                    end else begin
                        case (axis_state[i])
                            RPT_DELAY: begin
                                if (REPEAT_DELAY == 0) begin
                                    axis_cnt[i] <= '0;
                                end else if (axis_cnt[i] == DELAY_LAST) begin
                                    axis_pos_evt[i] <= axis_pos[i];
                                    axis_neg_evt[i] <= axis_neg[i];
                                    axis_state[i]   <= RPT_REPEAT;
                                    axis_cnt[i]     <= '0;
                                end else begin
                                    axis_cnt[i] <= axis_cnt[i] + RPT_W'(1);
                                end
                            end
                            RPT_REPEAT: begin
                                if (axis_cnt[i] == PERIOD_LAST) begin
                                    axis_pos_evt[i] <= axis_pos[i];
                                    axis_neg_evt[i] <= axis_neg[i];
                                    axis_cnt[i]     <= '0;
                                end else begin
                                    axis_cnt[i] <= axis_cnt[i] + RPT_W'(1);
                                end
                            end
                            default: begin
                                axis_state[i] <= RPT_IDLE;
                                axis_cnt[i]   <= '0;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nunchuk_input_decoder.sv
// tb_nunchuk_input_decoder
// Self-checking bench for nunchuk_input_decoder. It uses directed scenarios plus a
// randomized frame stream. Expected values come from a frame-level reference model
// that tracks hold lengths and disagreement counts.
// The filter scenario runs only when NUNCHUK_ACCEL_FILTER_EN is defined.

module tb_nunchuk_input_decoder;

    localparam int ACCEL_W         = 10;
    localparam int CENTER          = 128;
    localparam int DEADZONE        = 40;
    localparam int DEBOUNCE_FRAMES = 3;
    localparam int REPEAT_DELAY    = 20;
    localparam int REPEAT_PERIOD   = 5;
    localparam int FILTER_SHIFT    = 2;

    logic               clk;
    logic               reset;
    logic               frame_valid;
    logic [7:0]         data_in [5:0];
    logic [7:0]         stick_x;
    logic [7:0]         stick_y;
    logic [ACCEL_W-1:0] accel_x;
    logic [ACCEL_W-1:0] accel_y;
    logic [ACCEL_W-1:0] accel_z;
    logic               z_btn;
    logic               c_btn;
    logic               z_press;
    logic               c_press;
    logic [3:0]         dir_level;
    logic [3:0]         dir_evt;

    int checks;
    int errors;

    // Reference model state.
    int       m_stick_x, m_stick_y;
    int       m_acc [3];
    bit       m_loaded;
    int       m_btn [2];
    int       m_mism [2];
    int       m_press [2];
    int       m_hold [2];
    int       m_hdir [2];
    logic [3:0] m_dir_level;
    logic [3:0] m_dir_evt;

    nunchuk_input_decoder #(
        .ACCEL_W(ACCEL_W), .CENTER(CENTER), .DEADZONE(DEADZONE),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD), .FILTER_SHIFT(FILTER_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .data_in(data_in),
        .stick_x(stick_x), .stick_y(stick_y),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .z_btn(z_btn), .c_btn(c_btn), .z_press(z_press), .c_press(c_press),
        .dir_level(dir_level), .dir_evt(dir_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4, input logic [7:0] b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic int axis_dir(input int v);
        if (v > CENTER + DEADZONE) return 1;
        if (v < CENTER - DEADZONE) return -1;
        return 0;
    endfunction

    // An event is due on the first held frame, then after the delay, then once per period.
    function automatic bit repeat_due(input int hold);
        if (hold == 1) return 1'b1;
        if (REPEAT_DELAY == 0) return 1'b0;
        if (hold < REPEAT_DELAY + 1) return 1'b0;
        return ((hold - REPEAT_DELAY - 1) % REPEAT_PERIOD) == 0;
    endfunction

    task automatic model_reset();
        m_stick_x   = CENTER;
        m_stick_y   = CENTER;
        m_loaded    = 1'b0;
        m_dir_level = '0;
        m_dir_evt   = '0;
        for (int k = 0; k < 3; k++) m_acc[k] = 0;
        for (int k = 0; k < 2; k++) begin
            m_btn[k] = 0; m_mism[k] = 0; m_press[k] = 0; m_hold[k] = 0; m_hdir[k] = 0;
        end
    endtask

    task automatic model_frame(input logic [47:0] f);
        int b [6];
        int raw [3];
        int rb [2];
        int d [2];
        bit ev [2];
        for (int i = 0; i < 6; i++) b[i] = int'(f[8*i +: 8]);
        m_stick_x = b[0];
        m_stick_y = b[1];
        raw[0] = (b[2] * 4 + ((b[5] >> 2) & 3)) >> (10 - ACCEL_W);
        raw[1] = (b[3] * 4 + ((b[5] >> 4) & 3)) >> (10 - ACCEL_W);
        raw[2] = (b[4] * 4 + ((b[5] >> 6) & 3)) >> (10 - ACCEL_W);
`ifdef NUNCHUK_ACCEL_FILTER_EN
        for (int k = 0; k < 3; k++) begin
            if (!m_loaded) m_acc[k] = raw[k];
            else           m_acc[k] = m_acc[k] + ((raw[k] - m_acc[k]) >>> FILTER_SHIFT);
        end
        m_loaded = 1'b1;
`else
        for (int k = 0; k < 3; k++) m_acc[k] = raw[k];
`endif
        rb[0] = ((b[5] & 1) == 0) ? 1 : 0;
        rb[1] = ((b[5] & 2) == 0) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            m_press[k] = 0;
            if (rb[k] != m_btn[k]) begin
                m_mism[k]++;
                if (m_mism[k] == DEBOUNCE_FRAMES) begin
                    m_btn[k]   = rb[k];
                    m_press[k] = rb[k];
                    m_mism[k]  = 0;
                end
            end else begin
                m_mism[k] = 0;
            end
        end
        d[0] = axis_dir(b[0]);
        d[1] = axis_dir(b[1]);
        for (int k = 0; k < 2; k++) begin
            if (d[k] == 0)               m_hold[k] = 0;
            else if (d[k] != m_hdir[k])  m_hold[k] = 1;
            else                         m_hold[k]++;
            m_hdir[k] = d[k];
            ev[k] = (d[k] != 0) && repeat_due(m_hold[k]);
        end
        m_dir_level = {d[1] == 1, d[1] == -1, d[0] == -1, d[0] == 1};
        m_dir_evt   = {ev[1] && d[1] == 1, ev[1] && d[1] == -1, ev[0] && d[0] == -1, ev[0] && d[0] == 1};
    endtask

    // Drive one frame for one cycle. Return on the next falling edge with outputs settled.
    task automatic send_frame(input logic [47:0] f);
        @(negedge clk);
        for (int i = 0; i < 6; i++) data_in[i] = f[8*i +: 8];
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        model_frame(f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({stick_x, stick_y} !== {8'd128, 8'd128}) begin
            errors++;
            $display("[TB] FAIL reset_stick: got %0d/%0d, want 128/128", stick_x, stick_y);
        end
        checks++;
        if ({accel_x, accel_y, accel_z} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_accel: got %h %h %h, want 0", accel_x, accel_y, accel_z);
        end
        checks++;
        if ({z_btn, c_btn, z_press, c_press, dir_level, dir_evt} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, want 0", {z_btn, c_btn, z_press, c_press, dir_level, dir_evt});
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_field_map();
        send_frame(mk(8'h80, 8'h80, 8'h12, 8'h34, 8'h56, 8'hE7));
        checks++;
        if ({accel_x, accel_y, accel_z} !== {10'h049, 10'h0D2, 10'h15B}) begin
            errors++;
            $display("[TB] FAIL field_accel: got %h %h %h, want 049 0d2 15b", accel_x, accel_y, accel_z);
        end
        checks++;
        if ({stick_x, stick_y, z_btn, c_btn, dir_level} !== {8'd128, 8'd128, 2'b00, 4'h0}) begin
            errors++;
            $display("[TB] FAIL field_misc: got x=%0d y=%0d z=%b c=%b dir=%b", stick_x, stick_y, z_btn, c_btn, dir_level);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({accel_x, accel_y, accel_z, stick_x} !== {10'h049, 10'h0D2, 10'h15B, 8'd128}) begin
            errors++;
            $display("[TB] FAIL field_hold: got %h %h %h %0d after idle", accel_x, accel_y, accel_z, stick_x);
        end
    endtask

    task automatic test_debounce();
        logic [7:0] seq [14] = '{8'hE6, 8'hE6, 8'hE7, 8'hE7, 8'hE6, 8'hE6, 8'hE6,
                                 8'hE6, 8'hE7, 8'hE7, 8'hE7, 8'hE4, 8'hE4, 8'hE4};
        logic [3:0] want [14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100,
                                  4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        for (int n = 0; n < 14; n++) begin
            send_frame(mk(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, seq[n]));
            checks++;
            if ({z_btn, z_press, c_btn, c_press} !== want[n]) begin
                errors++;
                $display("[TB] FAIL debounce_step%0d: got {z,zp,c,cp}=%b, want %b", n, {z_btn, z_press, c_btn, c_press}, want[n]);
            end
            @(negedge clk);
            checks++;
            if ({z_press, c_press} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL debounce_pulse_clear%0d: got %b, want 00", n, {z_press, c_press});
            end
        end
    endtask

    task automatic test_repeat();
        logic [31:0] evt_mask;
        evt_mask = '0;
        for (int n = 1; n <= 30; n++) begin
            send_frame(mk(8'd200, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
            if (dir_evt[0]) evt_mask[n] = 1'b1;
            checks++;
            if ({dir_level, dir_evt} !== {4'b0001, m_dir_evt}) begin
                errors++;
                $display("[TB] FAIL repeat_frame%0d: got lvl=%b evt=%b, want lvl=0001 evt=%b", n, dir_level, dir_evt, m_dir_evt);
            end
        end
        checks++;
        if (evt_mask !== ((32'd1 << 1) | (32'd1 << 21) | (32'd1 << 26))) begin
            errors++;
            $display("[TB] FAIL repeat_schedule: got mask %h, want %h", evt_mask, (32'd1 << 1) | (32'd1 << 21) | (32'd1 << 26));
        end
        for (int n = 0; n < 3; n++) begin
            send_frame(mk(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
            checks++;
            if ({dir_level, dir_evt} !== 8'h00) begin
                errors++;
                $display("[TB] FAIL repeat_release%0d: got lvl=%b evt=%b, want 0", n, dir_level, dir_evt);
            end
        end
        send_frame(mk(8'd200, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
        checks++;
        if (dir_evt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL repeat_rearm: got evt=%b, want 0001", dir_evt);
        end
    endtask

    task automatic test_deadzone();
        logic [7:0] xs [8]   = '{8'd168, 8'd169, 8'd0, 8'd255, 8'd88, 8'd87, 8'd128, 8'd255};
        logic [7:0] ys [8]   = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd169, 8'd0};
        logic [3:0] want [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b0010, 4'b1000, 4'b0101};
        for (int n = 0; n < 8; n++) begin
            send_frame(mk(xs[n], ys[n], 8'h00, 8'h00, 8'h00, 8'hE7));
            checks++;
            if ({dir_level, dir_evt} !== {want[n], m_dir_evt}) begin
                errors++;
                $display("[TB] FAIL deadzone_x%0d_y%0d: got lvl=%b evt=%b, want lvl=%b evt=%b", xs[n], ys[n], dir_level, dir_evt, want[n], m_dir_evt);
            end
        end
        send_frame(mk(8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
    endtask

    task automatic test_reversal();
        logic [31:0] evt_mask;
        evt_mask = '0;
        for (int n = 0; n < 5; n++) send_frame(mk(8'd200, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
        send_frame(mk(8'd20, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
        checks++;
        if ({dir_level, dir_evt} !== 8'b0010_0010) begin
            errors++;
            $display("[TB] FAIL reversal_immediate: got lvl=%b evt=%b, want 0010/0010", dir_level, dir_evt);
        end
        for (int n = 1; n < 26; n++) begin
            send_frame(mk(8'd20, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
            if (dir_evt[1]) evt_mask[n] = 1'b1;
            checks++;
            if (dir_evt !== m_dir_evt) begin
                errors++;
                $display("[TB] FAIL reversal_hold%0d: got evt=%b, want %b", n, dir_evt, m_dir_evt);
            end
        end
        checks++;
        if (evt_mask !== ((32'd1 << 20) | (32'd1 << 25))) begin
            errors++;
            $display("[TB] FAIL reversal_delay_restart: got mask %h, want %h", evt_mask, (32'd1 << 20) | (32'd1 << 25));
        end
    endtask

    task automatic test_reset_with_frame();
        for (int n = 0; n < 4; n++) send_frame(mk(8'd200, 8'h80, 8'h11, 8'h22, 8'h33, 8'hE4));
        @(negedge clk);
        data_in[0] = 8'd20; data_in[1] = 8'd0; data_in[2] = 8'hAA;
        data_in[3] = 8'hBB; data_in[4] = 8'hCC; data_in[5] = 8'hE4;
        frame_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        checks++;
        if ({stick_x, stick_y, accel_x, accel_y, accel_z} !== {8'd128, 8'd128, 30'd0}) begin
            errors++;
            $display("[TB] FAIL reset_frame_data: got x=%0d y=%0d a=%h %h %h", stick_x, stick_y, accel_x, accel_y, accel_z);
        end
        checks++;
        if ({z_btn, c_btn, z_press, c_press, dir_level, dir_evt} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_frame_ctrl: got %b, want 0", {z_btn, c_btn, z_press, c_press, dir_level, dir_evt});
        end
        send_frame(mk(8'd200, 8'h80, 8'h00, 8'h00, 8'h00, 8'hE7));
        checks++;
        if ({dir_level, dir_evt} !== 8'b0001_0001) begin
            errors++;
            $display("[TB] FAIL reset_frame_idle: got lvl=%b evt=%b, want 0001/0001", dir_level, dir_evt);
        end
    endtask

`ifdef NUNCHUK_ACCEL_FILTER_EN
    task automatic test_filter();
        logic [ACCEL_W-1:0] want [4] = '{10'd400, 10'd400, 10'd300, 10'd225};
        logic [7:0]         b2   [4] = '{8'd100, 8'd100, 8'd0, 8'd0};
        do_reset();
        for (int n = 0; n < 4; n++) begin
            send_frame(mk(8'h80, 8'h80, b2[n], 8'h00, 8'h00, 8'h03));
            checks++;
            if (accel_x !== want[n]) begin
                errors++;
                $display("[TB] FAIL filter_step%0d: got %0d, want %0d", n, accel_x, want[n]);
            end
        end
    endtask
`endif

    function automatic int pick_stick();
        case ($urandom_range(0, 5))
            0: return 128;
            1: return 200;
            2: return 20;
            3: return 168 + int'($urandom_range(0, 1));
            4: return 87 + int'($urandom_range(0, 1));
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_random();
        int x, y, gap;
        logic [7:0] b5;
        x = 128; y = 128; b5 = 8'hE7;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) x = pick_stick();
            if ($urandom_range(0, 5) == 0) y = pick_stick();
            if ($urandom_range(0, 4) == 0) b5[1:0] = 2'($urandom_range(0, 3));
            b5[7:2] = 6'($urandom);
            send_frame(mk(8'(x), 8'(y), 8'($urandom), 8'($urandom), 8'($urandom), b5));
            checks++;
            if ({stick_x, stick_y, accel_x, accel_y, accel_z, z_btn, c_btn, z_press, c_press, dir_level, dir_evt} !==
                {8'(m_stick_x), 8'(m_stick_y), ACCEL_W'(m_acc[0]), ACCEL_W'(m_acc[1]), ACCEL_W'(m_acc[2]),
                 1'(m_btn[0]), 1'(m_btn[1]), 1'(m_press[0]), 1'(m_press[1]), m_dir_level, m_dir_evt}) begin
                errors++;
                $display("[TB] FAIL random_frame%0d: got x=%0d y=%0d a=%h/%h/%h b=%b%b p=%b%b lvl=%b evt=%b want x=%0d y=%0d a=%h/%h/%h b=%0d%0d p=%0d%0d lvl=%b evt=%b",
                         n, stick_x, stick_y, accel_x, accel_y, accel_z, z_btn, c_btn, z_press, c_press, dir_level, dir_evt,
                         m_stick_x, m_stick_y, m_acc[0], m_acc[1], m_acc[2], m_btn[0], m_btn[1], m_press[0], m_press[1], m_dir_level, m_dir_evt);
            end
            gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                checks++;
                if ({z_press, c_press, dir_evt, dir_level, stick_x} !== {6'b0, m_dir_level, 8'(m_stick_x)}) begin
                    errors++;
                    $display("[TB] FAIL random_idle%0d: got p=%b%b evt=%b lvl=%b x=%0d, want p=00 evt=0000 lvl=%b x=%0d",
                             n, z_press, c_press, dir_evt, dir_level, stick_x, m_dir_level, m_stick_x);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        frame_valid = 1'b0;
        for (int i = 0; i < 6; i++) data_in[i] = 8'h00;
        model_reset();
        test_reset();
        test_field_map();
        test_debounce();
        test_repeat();
        test_deadzone();
        test_reversal();
        test_reset_with_frame();
`ifdef NUNCHUK_ACCEL_FILTER_EN
        test_filter();
`endif
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
